fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000: instruction word placed in a bubbled IF/ID register.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold PC and IF/ID register (hazard from decode).
REQ-006 redirect  input  1  taken branch/jump; load redirect_target, squash current fetch.
REQ-007 redirect_target  input  32  byte address of new fetch PC.
REQ-008 imem_addr  output  32  byte address to IMEM; combinationally equal to current_pc.
REQ-009 imem_instruction  input  32  IMEM combinational read data for imem_addr.
REQ-010 current_pc  output  32  PC register.
REQ-011 if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-012 if_id_instr  output  32  latched instruction.
REQ-013 if_id_pc  output  32  PC of latched instruction.
REQ-014 if_id_pc_plus4  output  32  if_id_pc + 4.
REQ-015 fetch_count  output  32  number of instructions latched with valid=1 since reset.
REQ-016 misalign_err  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-017 Per-edge priority SHALL be: reset > redirect > stall > normal advance.
REQ-018 Normal advance: current_pc <= current_pc + 4; if_id_instr <= imem_instruction; if_id_pc <= current_pc; if_id_pc_plus4 <= current_pc + 4; if_id_valid <= 1.
REQ-019 Fetch latency SHALL be one cycle: the instruction at address A appears on if_id_instr the edge after imem_addr = A.
REQ-020 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-021 Stall (redirect=0): current_pc and all IF/ID outputs SHALL hold; fetch_count SHALL not increment.
REQ-022 Redirect: current_pc <= redirect_target; if_id_valid <= 0; if_id_instr <= NOP_INSTR; if_id_pc and if_id_pc_plus4 <= 0; the word fetched that cycle is discarded.
REQ-023 Redirect and stall asserted together: redirect SHALL win in full per REQ-022.
REQ-024 Back-to-back redirects: each SHALL reload the PC; IF/ID stays invalid until the first non-redirect, non-stall edge.
REQ-025 fetch_count SHALL increment by 1 exactly on edges where if_id_valid is loaded with 1, and SHALL wrap 32'hFFFF_FFFF -> 0.
REQ-026 The block SHALL never check alignment on sequential advance; PC bits [1:0] change only via redirect.

Reset
REQ-027 With reset=1 at an edge: current_pc=RESET_PC, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0, fetch_count=0, misalign_err=0.
REQ-028 Reset SHALL override stall and redirect in the same cycle.
REQ-029 Reset asserted mid-stream SHALL discard any in-flight instruction; the first valid instruction after release is the one at RESET_PC, one edge after release.

Configuration
REQ-030 Macro FETCH_ALIGN_CHECK_EN defined: a redirect with redirect_target[1:0] != 2'b00 SHALL be ignored (PC and IF/ID advance as if redirect=0) and SHALL set misalign_err=1 until reset.
REQ-031 Macro undefined: redirect_target SHALL be loaded unchanged regardless of bits [1:0]; misalign_err SHALL be tied to 0.

Verification
REQ-032 Reset 2 cycles, release, IMEM word[i]=32'h1000_0000+i for 8 cycles -> if_id_pc 0,4,...,0x1C with matching instr; fetch_count=8; first valid one edge after release.
REQ-033 Stall for 3 cycles after if_id_pc=0x8 -> current_pc holds 0xC, if_id_pc holds 0x8, fetch_count frozen; resumes with if_id_pc=0xC.
REQ-034 Redirect to 0x40 while current_pc=0x10, stall also high -> next edge current_pc=0x40, if_id_valid=0, if_id_instr=NOP_INSTR; following edge if_id_pc=0x40, valid=1.
REQ-035 RESET_PC=32'hFFFF_FFF8 -> if_id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; if_id_pc_plus4 for last = 0x4.
REQ-036 With FETCH_ALIGN_CHECK_EN: redirect to 0x42 at current_pc=0x20 -> current_pc=0x24, misalign_err=1 and sticky; without macro -> current_pc=0x42, misalign_err=0.
REQ-037 Assert reset at if_id_pc=0x14 -> next edge all outputs at reset values per REQ-027; fetch restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter.
// Optional macro FETCH_ALIGN_CHECK_EN rejects misaligned redirects and flags them.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instruction,
  output logic [31:0] current_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] fetch_count,
  output logic        misalign_err
);

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifpc4_q, ifpc4_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;
  logic        misalign_hit;
  logic        take_redirect;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign misalign_hit = redirect && (redirect_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (misalign_hit) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_err = misalign_q;
`else
  assign misalign_hit = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // A rejected misaligned redirect behaves exactly as if redirect were low.
  assign take_redirect = redirect && !misalign_hit;
  assign pc_plus4      = pc_q + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifpc4_d = ifpc4_q;
    count_d = count_q;
    if (take_redirect) begin
      pc_d    = redirect_target;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      ifpc_d  = 32'h0;
      ifpc4_d = 32'h0;
    end else if (!stall) begin
      pc_d    = pc_plus4;
      valid_d = 1'b1;
      instr_d = imem_instruction;
      ifpc_d  = pc_q;
      ifpc4_d = pc_plus4;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      ifpc_q  <= 32'h0;
      ifpc4_q <= 32'h0;
      count_q <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc4_q <= ifpc4_d;
      count_q <= count_d;
    end
  end

  assign imem_addr      = pc_q;
  assign current_pc     = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ifpc_q;
  assign if_id_pc_plus4 = ifpc4_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; IMEM word at byte address A is
// 32'h1000_0000 + A/4. A second instance covers PC wrap and a non-zero NOP_INSTR.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr, imem_instruction, current_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;
  logic        misalign_err;

  logic        w_reset, w_stall, w_redirect;
  logic [31:0] w_redirect_target;
  logic [31:0] w_imem_addr, w_imem_instruction, w_current_pc;
  logic        w_if_id_valid;
  logic [31:0] w_if_id_instr, w_if_id_pc, w_if_id_pc_plus4, w_fetch_count;
  logic        w_misalign_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign imem_instruction   = 32'h1000_0000 + (imem_addr >> 2);
  assign w_imem_instruction = 32'h1000_0000 + (w_imem_addr >> 2);

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_target  (redirect_target),
    .imem_addr        (imem_addr),
    .imem_instruction (imem_instruction),
    .current_pc       (current_pc),
    .if_id_valid      (if_id_valid),
    .if_id_instr      (if_id_instr),
    .if_id_pc         (if_id_pc),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .fetch_count      (fetch_count),
    .misalign_err     (misalign_err)
  );

  fetch_stage #(
    .RESET_PC  (32'hFFFF_FFF8),
    .NOP_INSTR (32'h0000_0013)
  ) dut_w (
    .clk              (clk),
    .reset            (w_reset),
    .stall            (w_stall),
    .redirect         (w_redirect),
    .redirect_target  (w_redirect_target),
    .imem_addr        (w_imem_addr),
    .imem_instruction (w_imem_instruction),
    .current_pc       (w_current_pc),
    .if_id_valid      (w_if_id_valid),
    .if_id_instr      (w_if_id_instr),
    .if_id_pc         (w_if_id_pc),
    .if_id_pc_plus4   (w_if_id_pc_plus4),
    .fetch_count      (w_fetch_count),
    .misalign_err     (w_misalign_err)
  );

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_target = 32'h0000_0080;
    step();
    step();
    tests++; if (current_pc !== 32'h0) begin fails++;
      $display("FAIL reset_pc: got %h want %h", current_pc, 32'h0); end
    tests++; if (imem_addr !== 32'h0) begin fails++;
      $display("FAIL reset_imem_addr: got %h want %h", imem_addr, 32'h0); end
    tests++; if (if_id_valid !== 1'b0) begin fails++;
      $display("FAIL reset_valid: got %b want 0", if_id_valid); end
    tests++; if (if_id_instr !== 32'h0) begin fails++;
      $display("FAIL reset_instr: got %h want %h", if_id_instr, 32'h0); end
    tests++; if (if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0) begin fails++;
      $display("FAIL reset_ifid_pc: got %h/%h want 0/0", if_id_pc, if_id_pc_plus4); end
    tests++; if (fetch_count !== 32'h0 || misalign_err !== 1'b0) begin fails++;
      $display("FAIL reset_count_err: got %h/%b want 0/0", fetch_count, misalign_err); end
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * i) ||
          if_id_instr !== 32'h1000_0000 + 32'(i) || if_id_pc_plus4 !== 32'(4 * i + 4)) begin
        fails++;
        $display("FAIL seq_%0d: got v=%b pc=%h instr=%h pc4=%h want v=1 pc=%h instr=%h pc4=%h",
                 i, if_id_valid, if_id_pc, if_id_instr, if_id_pc_plus4, 32'(4 * i),
                 32'h1000_0000 + 32'(i), 32'(4 * i + 4));
      end
    end
    tests++; if (fetch_count !== 32'd8 || current_pc !== 32'h20) begin fails++;
      $display("FAIL seq_count: got cnt=%0d pc=%h want cnt=8 pc=20", fetch_count, current_pc); end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step(); step();
    tests++; if (if_id_pc !== 32'h8 || current_pc !== 32'hC || fetch_count !== 32'd3) begin
      fails++;
      $display("FAIL stall_setup: got ifpc=%h pc=%h cnt=%0d want 8/c/3", if_id_pc, current_pc,
               fetch_count);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (current_pc !== 32'hC || if_id_pc !== 32'h8 || fetch_count !== 32'd3 ||
          if_id_instr !== 32'h1000_0002 || if_id_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold_%0d: got pc=%h ifpc=%h cnt=%0d instr=%h want c/8/3/10000002",
                 i, current_pc, if_id_pc, fetch_count, if_id_instr);
      end
    end
    stall = 1'b0;
    step();
    tests++; if (if_id_pc !== 32'hC || if_id_instr !== 32'h1000_0003 || fetch_count !== 32'd4)
      begin fails++;
      $display("FAIL stall_resume: got ifpc=%h instr=%h cnt=%0d want c/10000003/4", if_id_pc,
               if_id_instr, fetch_count); end
  endtask

  task automatic test_redirect_stall();
    tests++; if (current_pc !== 32'h10) begin fails++;
      $display("FAIL redir_setup: got pc=%h want 10", current_pc); end
    redirect = 1'b1; redirect_target = 32'h40; stall = 1'b1;
    step();
    tests++; if (current_pc !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
                 if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0 || fetch_count !== 32'd4) begin
      fails++;
      $display("FAIL redir_squash: got pc=%h v=%b instr=%h ifpc=%h pc4=%h cnt=%0d want 40/0/0/0/0/4",
               current_pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count);
    end
    redirect = 1'b0; stall = 1'b0;
    step();
    tests++; if (if_id_pc !== 32'h40 || if_id_valid !== 1'b1 || if_id_instr !== 32'h1000_0010 ||
                 fetch_count !== 32'd5) begin fails++;
      $display("FAIL redir_target: got ifpc=%h v=%b instr=%h cnt=%0d want 40/1/10000010/5",
               if_id_pc, if_id_valid, if_id_instr, fetch_count); end
  endtask

  task automatic test_back_to_back();
    redirect = 1'b1; redirect_target = 32'h100;
    step();
    redirect_target = 32'h200;
    step();
    tests++; if (current_pc !== 32'h200 || if_id_valid !== 1'b0 || fetch_count !== 32'd5) begin
      fails++;
      $display("FAIL b2b_redirect: got pc=%h v=%b cnt=%0d want 200/0/5", current_pc, if_id_valid,
               fetch_count); end
    redirect = 1'b0;
    step();
    tests++; if (if_id_pc !== 32'h200 || if_id_valid !== 1'b1 || fetch_count !== 32'd6) begin
      fails++;
      $display("FAIL b2b_resume: got ifpc=%h v=%b cnt=%0d want 200/1/6", if_id_pc, if_id_valid,
               fetch_count); end
  endtask

  task automatic test_wrap();
    w_reset = 1'b1; w_stall = 1'b1; w_redirect = 1'b1; w_redirect_target = 32'h40;
    step();
    tests++; if (w_current_pc !== 32'hFFFF_FFF8 || w_if_id_instr !== 32'h13 ||
                 w_if_id_valid !== 1'b0) begin fails++;
      $display("FAIL wrap_reset: got pc=%h instr=%h v=%b want fffffff8/13/0", w_current_pc,
               w_if_id_instr, w_if_id_valid); end
    w_reset = 1'b0; w_stall = 1'b0; w_redirect = 1'b0;
    step();
    tests++; if (w_if_id_pc !== 32'hFFFF_FFF8 || w_if_id_instr !== 32'h4FFF_FFFE) begin fails++;
      $display("FAIL wrap_0: got ifpc=%h instr=%h want fffffff8/4ffffffe", w_if_id_pc,
               w_if_id_instr); end
    step();
    tests++; if (w_if_id_pc !== 32'hFFFF_FFFC || w_if_id_pc_plus4 !== 32'h0) begin fails++;
      $display("FAIL wrap_1: got ifpc=%h pc4=%h want fffffffc/0", w_if_id_pc, w_if_id_pc_plus4);
    end
    step();
    tests++; if (w_if_id_pc !== 32'h0 || w_if_id_pc_plus4 !== 32'h4 ||
                 w_if_id_instr !== 32'h1000_0000 || w_fetch_count !== 32'd3) begin fails++;
      $display("FAIL wrap_2: got ifpc=%h pc4=%h instr=%h cnt=%0d want 0/4/10000000/3",
               w_if_id_pc, w_if_id_pc_plus4, w_if_id_instr, w_fetch_count); end
  endtask

  task automatic test_misalign();
    do_reset();
    for (int i = 0; i < 8; i++) step();
    tests++; if (current_pc !== 32'h20) begin fails++;
      $display("FAIL misalign_setup: got pc=%h want 20", current_pc); end
    redirect = 1'b1; redirect_target = 32'h42;
    step();
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    tests++; if (current_pc !== 32'h24 || misalign_err !== 1'b1 || if_id_pc !== 32'h20 ||
                 if_id_valid !== 1'b1) begin fails++;
      $display("FAIL misalign_reject: got pc=%h err=%b ifpc=%h v=%b want 24/1/20/1", current_pc,
               misalign_err, if_id_pc, if_id_valid); end
    step();
    tests++; if (misalign_err !== 1'b1 || current_pc !== 32'h28) begin fails++;
      $display("FAIL misalign_sticky: got err=%b pc=%h want 1/28", misalign_err, current_pc); end
`else
    tests++; if (current_pc !== 32'h42 || misalign_err !== 1'b0 || if_id_valid !== 1'b0) begin
      fails++;
      $display("FAIL misalign_load: got pc=%h err=%b v=%b want 42/0/0", current_pc, misalign_err,
               if_id_valid); end
    step();
    tests++; if (if_id_pc !== 32'h42 || current_pc !== 32'h46 || misalign_err !== 1'b0) begin
      fails++;
      $display("FAIL misalign_fetch: got ifpc=%h pc=%h err=%b want 42/46/0", if_id_pc,
               current_pc, misalign_err); end
`endif
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 6; i++) step();
    tests++; if (if_id_pc !== 32'h14) begin fails++;
      $display("FAIL midreset_setup: got ifpc=%h want 14", if_id_pc); end
    reset = 1'b1;
    step();
    tests++; if (current_pc !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
                 if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h0 || fetch_count !== 32'h0 ||
                 misalign_err !== 1'b0) begin fails++;
      $display("FAIL midreset_state: got pc=%h v=%b instr=%h ifpc=%h pc4=%h cnt=%0d err=%b want 0",
               current_pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count,
               misalign_err); end
    reset = 1'b0;
    step();
    tests++; if (if_id_pc !== 32'h0 || if_id_valid !== 1'b1 || if_id_instr !== 32'h1000_0000 ||
                 fetch_count !== 32'd1) begin fails++;
      $display("FAIL midreset_restart: got ifpc=%h v=%b instr=%h cnt=%0d want 0/1/10000000/1",
               if_id_pc, if_id_valid, if_id_instr, fetch_count); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    w_reset = 1'b1; w_stall = 1'b0; w_redirect = 1'b0; w_redirect_target = 32'h0;
    #2;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_back_to_back();
    test_wrap();
    test_misalign();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
